stark_fence_sequencer: RTL
==========================

// Module: stark_fence_sequencer
// PURPOSE
//  Consumes the decoded FENCE flag at dispatch and enforces memory ordering:
//  counts in-flight loads/stores, stalls dispatch while a fence drains the
//  selected classes, then pulses completion. Sits directly after fence decode.
// PARAMETERS
//  CNTW     6     width of each outstanding-op counter (max 2**CNTW-1)
//  TIMEOUT  1024  drain-cycle limit before forced completion (STARK_FENCE_TIMEOUT_EN only)
// PORTS
//  clk               in   1     clock
//  rst_n             in   1     asynchronous reset, active-low
//  fence_valid_i     in   1     decoded instruction is a FENCE
//  fence_mask_i      in   2     bit0 = wait loads, bit1 = wait stores
//  fence_ready_o     out  1     sequencer can accept a fence (state IDLE)
//  ld_issue_i        in   1     one load issued to memory this cycle
//  ld_done_i         in   1     one load completed this cycle
//  st_issue_i        in   1     one store issued this cycle
//  st_done_i         in   1     one store completed/committed this cycle
//  dispatch_stall_o  out  1     block dispatch of younger instructions
//  fence_done_o      out  1     one-cycle pulse: fence retired
//  ld_cnt_o          out  CNTW  loads outstanding
//  st_cnt_o          out  CNTW  stores outstanding
//  cnt_err_o         out  1     sticky counter overflow/underflow
//  timeout_o         out  1     one-cycle pulse: fence forced by timeout
// BEHAVIOUR
//  - Reset (rst_n low, async): state IDLE, counters 0, latched mask 0,
//    cnt_err_o 0, fence_done_o 0, timeout_o 0; fence_ready_o 1, stall 0.
//  - Counters update every cycle in all states: +issue -done; issue&done same
//    cycle = no change. Issue at max: hold, set cnt_err_o. Done at 0: hold,
//    set cnt_err_o. cnt_err_o clears only on reset.
//  - FSM IDLE -> DRAIN -> DONE -> IDLE.
//    IDLE: fence_ready_o=1; fence_valid_i accepted at edge T, mask latched.
//    DRAIN (T+1..): exits to DONE at first edge where every masked counter
//      is 0 and no masked-class issue is asserted that cycle.
//    DONE: fence_done_o=1 for exactly this cycle; next edge -> IDLE.
//  - Minimum latency: accept at T, DONE at T+2, ready again at T+3.
//    Mask 00 follows the same path (no wait, still 2-cycle latency).
//  - dispatch_stall_o = (state != IDLE) | fence_valid_i (combinational, so
//    the fence's own dispatch cycle stalls younger ops).
//  - fence_valid_i outside IDLE is ignored; upstream holds it until ready.
//  - Reset mid-DRAIN abandons the fence; no fence_done_o is generated.
// CONFIGURATION
//  STARK_FENCE_TIMEOUT_EN defined: drain counter (clog2(TIMEOUT+1) bits) clears
//   on entry to DRAIN, increments each DRAIN cycle; when it reaches TIMEOUT
//   the FSM goes to DONE and timeout_o pulses with fence_done_o.
//  Undefined: no drain counter; timeout_o tied 0; DRAIN waits indefinitely.
// TESTING
//  - Reset, mask=11, counters 0, fence at T -> fence_done_o at T+2, ready at T+3.
//  - 3 loads issued, fence mask=01 -> stall held; 3rd ld_done_i at cycle C ->
//    done at C+2; stores outstanding during drain do not delay it.
//  - ld_issue_i & ld_done_i together with ld_cnt_o=5 -> stays 5; done at 0 ->
//    cnt_err_o=1 and count stays 0; 64th issue with CNTW=6 -> err, holds 63.
//  - fence_valid_i held during DRAIN -> second fence accepted only after
//    IDLE returns; exactly two fence_done_o pulses.
//  - rst_n low mid-DRAIN with st_cnt_o=2 -> all outputs at reset values
//    immediately, no fence_done_o.
//  - TIMEOUT_EN, TIMEOUT=16, store never completes -> fence_done_o and
//    timeout_o together 16 cycles after DRAIN entry; without macro, stall holds.

Source files
------------

// File: rtl/stark_fence_sequencer.sv
// FENCE sequencer: tracks outstanding loads/stores and stalls dispatch until a fence drains.
// Optional forced completion after TIMEOUT drain cycles when STARK_FENCE_TIMEOUT_EN is defined.
module stark_fence_sequencer #(
  parameter int CNTW    = 6,
  parameter int TIMEOUT = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fence_valid_i,
  input  logic [1:0]      fence_mask_i,
  output logic            fence_ready_o,
  input  logic            ld_issue_i,
  input  logic            ld_done_i,
  input  logic            st_issue_i,
  input  logic            st_done_i,
  output logic            dispatch_stall_o,
  output logic            fence_done_o,
  output logic [CNTW-1:0] ld_cnt_o,
  output logic [CNTW-1:0] st_cnt_o,
  output logic            cnt_err_o,
  output logic            timeout_o
);

  typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

  localparam logic [CNTW-1:0] CNT_MAX = '1;

  state_t          state_q, state_d;
  logic [1:0]      mask_q;
  logic [CNTW-1:0] ld_cnt_q, st_cnt_q;
  logic            err_q;
  logic            ld_inc, ld_dec, st_inc, st_dec;
  logic            ld_bad, st_bad;
  logic            drained, force_exit;

  // Simultaneous issue and done cancel out, so only the one-sided cases move a counter.
  assign ld_inc = ld_issue_i & ~ld_done_i;
  assign ld_dec = ld_done_i & ~ld_issue_i;
  assign st_inc = st_issue_i & ~st_done_i;
  assign st_dec = st_done_i & ~st_issue_i;
  assign ld_bad = (ld_inc & (ld_cnt_q == CNT_MAX)) | (ld_dec & (ld_cnt_q == '0));
  assign st_bad = (st_inc & (st_cnt_q == CNT_MAX)) | (st_dec & (st_cnt_q == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_cnt_q <= '0;
      st_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (ld_inc && ld_cnt_q != CNT_MAX) ld_cnt_q <= ld_cnt_q + 1'b1;
      else if (ld_dec && ld_cnt_q != '0) ld_cnt_q <= ld_cnt_q - 1'b1;
      if (st_inc && st_cnt_q != CNT_MAX) st_cnt_q <= st_cnt_q + 1'b1;
      else if (st_dec && st_cnt_q != '0) st_cnt_q <= st_cnt_q - 1'b1;
      if (ld_bad || st_bad) err_q <= 1'b1;
    end
  end

  // A masked class is clear only if its count is zero and nothing new of that class issues now.
  assign drained = (~mask_q[0] | ((ld_cnt_q == '0) & ~ld_issue_i)) &
                   (~mask_q[1] | ((st_cnt_q == '0) & ~st_issue_i));

`ifdef STARK_FENCE_TIMEOUT_EN
  localparam int DW = $clog2(TIMEOUT + 1);
  logic [DW-1:0] dcnt_q;
  logic          to_q;

  assign force_exit = (state_q == DRAIN) && (dcnt_q == DW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt_q <= '0;
      to_q   <= 1'b0;
    end else begin
      if (state_q == DRAIN) dcnt_q <= dcnt_q + 1'b1;
      else                  dcnt_q <= '0;
      if (state_q == DRAIN && state_d == DONE) to_q <= ~drained;
      else if (state_q == DONE)                to_q <= 1'b0;
    end
  end

  assign timeout_o = (state_q == DONE) & to_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign force_exit     = 1'b0;
  assign timeout_o      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mask_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && fence_valid_i) mask_q <= fence_mask_i;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fence_valid_i) state_d = DRAIN;
      DRAIN:   if (drained || force_exit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign fence_ready_o    = (state_q == IDLE);
  assign dispatch_stall_o = (state_q != IDLE) | fence_valid_i;
  assign fence_done_o     = (state_q == DONE);
  assign ld_cnt_o         = ld_cnt_q;
  assign st_cnt_o         = st_cnt_q;
  assign cnt_err_o        = err_q;

endmodule
